axi4_sram_slave: RTL and testbench

//  AXI4 slave responder: the target end of the core's io_master AXI4 port.

---
 rtl/axi4_sram_slave_if.sv | 51 +++++
 rtl/axi4_sram_slave.sv | 261 ++++++++++++++++++++++++++
 tb/tb_axi4_sram_slave.sv | 542 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_sram_slave_if.sv
// AXI4 bus bundle between the io_master port and the SRAM slave.
// slave modport: target end; master modport: initiator end.
interface axi4_sram_slave_if;
    logic        awready;
    logic        awvalid;
    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        wready;
    logic        wvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        bready;
    logic        bvalid;
    logic [1:0]  bresp;
    logic [3:0]  bid;
    logic        arready;
    logic        arvalid;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rready;
    logic        rvalid;
    logic [1:0]  rresp;
    logic [31:0] rdata;
    logic        rlast;
    logic [3:0]  rid;

    modport slave (
        output awready, wready, bvalid, bresp, bid,
        output arready, rvalid, rresp, rdata, rlast, rid,
        input  awvalid, awaddr, awid, awlen, awsize, awburst,
        input  wvalid, wdata, wstrb, wlast, bready,
        input  arvalid, araddr, arid, arlen, arsize, arburst,
        input  rready
    );

    modport master (
        input  awready, wready, bvalid, bresp, bid,
        input  arready, rvalid, rresp, rdata, rlast, rid,
        output awvalid, awaddr, awid, awlen, awsize, awburst,
        output wvalid, wdata, wstrb, wlast, bready,
        output arvalid, araddr, arid, arlen, arsize, arburst,
        output rready
    );
endinterface

// File: rtl/axi4_sram_slave.sv
// AXI4 slave backed by a word-addressed SRAM; independent read/write FSMs.
// Ports: clock, reset (sync, active-high), io_slave (AXI4 slave modport).
module axi4_sram_slave #(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          RD_LATENCY  = 1
) (
    input  logic             clock,
    input  logic             reset,
    axi4_sram_slave_if.slave io_slave
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

    logic [31:0] mem [DEPTH_WORDS];

    // Offset is unsigned mod 2^32, so addresses below the base decode out.
    function automatic logic dec_err(input logic [31:0] a);
        return ((a - ADDR_BASE) >> (AW + 2)) != 32'd0;
    endfunction

    function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
        return AW'((a - ADDR_BASE) >> 2);
    endfunction

    function automatic logic [31:0] step(
        input logic [2:0] size,
        input logic [1:0] burst
    );
        return (burst == 2'b00) ? 32'd0 : (32'd1 << size);
    endfunction

    function automatic logic bad_ctl(
        input logic [2:0] size,
        input logic [1:0] burst
    );
        return (size > 3'd2) || burst[1];
    endfunction

    // ---------------- write channel ----------------
    w_state_t    w_state;
    logic [31:0] w_addr;
    logic [3:0]  w_id;
    logic [7:0]  w_len;
    logic [7:0]  w_cnt;
    logic [2:0]  w_size;
    logic [1:0]  w_burst;
    logic        w_ill;
    logic [1:0]  w_err;

    logic        w_fire;
    logic        w_last;
    logic        w_dec;
    logic        w_we;
    logic [1:0]  w_beat_err;
    logic [1:0]  w_err_next;
    logic [AW-1:0] w_idx;

    assign w_fire = io_slave.wvalid && io_slave.wready;
    assign w_last = (w_cnt == w_len);
    assign w_dec  = dec_err(w_addr);
    assign w_idx  = word_idx(w_addr);
    assign w_we   = w_fire && !w_dec && !w_ill && !reset;

    // Response codes order by severity numerically: 11 > 10 > 00.
    assign w_beat_err = w_dec ? 2'b11 :
        (w_ill || (io_slave.wlast != w_last)) ? 2'b10 : 2'b00;
    assign w_err_next = (w_beat_err > w_err) ? w_beat_err : w_err;

    always_ff @(posedge clock) begin
        if (w_we) begin
            for (int i = 0; i < 4; i++) begin
                if (io_slave.wstrb[i]) begin
                    mem[w_idx][8*i +: 8] <= io_slave.wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            w_state          <= W_IDLE;
            w_addr           <= '0;
            w_id             <= '0;
            w_len            <= '0;
            w_cnt            <= '0;
            w_size           <= '0;
            w_burst          <= '0;
            w_ill            <= 1'b0;
            w_err            <= '0;
            io_slave.awready <= 1'b0;
            io_slave.wready  <= 1'b0;
            io_slave.bvalid  <= 1'b0;
            io_slave.bresp   <= '0;
            io_slave.bid     <= '0;
        end else begin
            unique case (w_state)
                W_IDLE: begin
                    io_slave.awready <= 1'b1;
                    if (io_slave.awvalid && io_slave.awready) begin
                        io_slave.awready <= 1'b0;
                        io_slave.wready  <= 1'b1;
                        w_addr  <= io_slave.awaddr;
                        w_id    <= io_slave.awid;
                        w_len   <= io_slave.awlen;
                        w_size  <= io_slave.awsize;
                        w_burst <= io_slave.awburst;
                        w_ill   <= bad_ctl(io_slave.awsize,
                                           io_slave.awburst);
                        w_cnt   <= '0;
                        w_err   <= '0;
                        w_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        w_cnt  <= w_cnt + 8'd1;
                        w_addr <= w_addr + step(w_size, w_burst);
                        w_err  <= w_err_next;
                        // Beat count alone closes the burst.
                        if (w_last) begin
                            io_slave.wready <= 1'b0;
                            io_slave.bvalid <= 1'b1;
                            io_slave.bresp  <= w_err_next;
                            io_slave.bid    <= w_id;
                            w_state         <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (io_slave.bready) begin
                        io_slave.bvalid  <= 1'b0;
                        io_slave.awready <= 1'b1;
                        w_state          <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // ---------------- read channel ----------------
    r_state_t    r_state;
    logic [31:0] r_addr;
    logic [3:0]  r_id;
    logic [7:0]  r_len;
    logic [7:0]  r_cnt;
    logic [2:0]  r_size;
    logic [1:0]  r_burst;
    logic        r_ill;
    logic [7:0]  r_lat;

    logic        r_fire;
    logic [31:0] r_addr_next;
    logic [31:0] ld_addr;
    logic        ld_ill;
    logic        ld_dec;
    logic [1:0]  ld_resp;
    logic [31:0] ld_data;

    assign r_fire      = io_slave.rvalid && io_slave.rready;
    assign r_addr_next = r_addr + step(r_size, r_burst);

    // Address of the beat being loaded into the output register this edge.
    always_comb begin
        ld_addr = r_addr;
        ld_ill  = r_ill;
        unique case (r_state)
            R_IDLE: begin
                ld_addr = io_slave.araddr;
                ld_ill  = bad_ctl(io_slave.arsize, io_slave.arburst);
            end
            R_DATA:  ld_addr = r_addr_next;
            default: ld_addr = r_addr;
        endcase
    end

    assign ld_dec  = dec_err(ld_addr);
    assign ld_resp = ld_dec ? 2'b11 : (ld_ill ? 2'b10 : 2'b00);
    assign ld_data = (ld_dec || ld_ill) ? 32'd0 : mem[word_idx(ld_addr)];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state          <= R_IDLE;
            r_addr           <= '0;
            r_id             <= '0;
            r_len            <= '0;
            r_cnt            <= '0;
            r_size           <= '0;
            r_burst          <= '0;
            r_ill            <= 1'b0;
            r_lat            <= '0;
            io_slave.arready <= 1'b0;
            io_slave.rvalid  <= 1'b0;
            io_slave.rresp   <= '0;
            io_slave.rdata   <= '0;
            io_slave.rlast   <= 1'b0;
            io_slave.rid     <= '0;
        end else begin
            unique case (r_state)
                R_IDLE: begin
                    io_slave.arready <= 1'b1;
                    if (io_slave.arvalid && io_slave.arready) begin
                        io_slave.arready <= 1'b0;
                        r_addr  <= io_slave.araddr;
                        r_id    <= io_slave.arid;
                        r_len   <= io_slave.arlen;
                        r_size  <= io_slave.arsize;
                        r_burst <= io_slave.arburst;
                        r_ill   <= ld_ill;
                        r_cnt   <= '0;
                        r_lat   <= '0;
                        if (RD_LATENCY == 1) begin
                            io_slave.rvalid <= 1'b1;
                            io_slave.rdata  <= ld_data;
                            io_slave.rresp  <= ld_resp;
                            io_slave.rlast  <= (io_slave.arlen == 8'd0);
                            io_slave.rid    <= io_slave.arid;
                            r_state         <= R_DATA;
                        end else begin
                            r_state <= R_WAIT;
                        end
                    end
                end
                R_WAIT: begin
                    if (r_lat == 8'(RD_LATENCY - 2)) begin
                        io_slave.rvalid <= 1'b1;
                        io_slave.rdata  <= ld_data;
                        io_slave.rresp  <= ld_resp;
                        io_slave.rlast  <= (r_len == 8'd0);
                        io_slave.rid    <= r_id;
                        r_state         <= R_DATA;
                    end else begin
                        r_lat <= r_lat + 8'd1;
                    end
                end
                R_DATA: begin
                    if (r_fire) begin
                        if (io_slave.rlast) begin
                            io_slave.rvalid  <= 1'b0;
                            io_slave.rlast   <= 1'b0;
                            io_slave.arready <= 1'b1;
                            r_state          <= R_IDLE;
                        end else begin
                            r_cnt          <= r_cnt + 8'd1;
                            r_addr         <= r_addr_next;
                            io_slave.rdata <= ld_data;
                            io_slave.rresp <= ld_resp;
                            io_slave.rlast <= (r_cnt + 8'd1 == r_len);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_sram_slave.sv
// Directed testbench for axi4_sram_slave.
// Drives the AXI4 master side through the bus interface.
module tb_axi4_sram_slave;

    logic clock;
    logic reset;
    int   total;
    int   bad;

    logic [31:0] wbuf [16];
    logic [31:0] rbuf [16];
    logic [1:0]  rrsp [16];
    logic        rlst [16];
    logic [3:0]  rids [16];

    axi4_sram_slave_if bus ();

    axi4_sram_slave dut (
        .clock    (clock),
        .reset    (reset),
        .io_slave (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic aw_send(
        input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
        input logic [2:0] size, input logic [1:0] burst
    );
        bit ok = 1'b0;
        bus.awaddr  = a;
        bus.awid    = id;
        bus.awlen   = len;
        bus.awsize  = size;
        bus.awburst = burst;
        bus.awvalid = 1'b1;
        for (int k = 0; k < 200 && !ok; k++) begin
            ok = bus.awready;
            tick();
        end
        bus.awvalid = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL aw_timeout got=none want=handshake");
        end
    endtask

    task automatic w_send(
        input logic [31:0] d, input logic [3:0] strb, input logic last
    );
        bit ok = 1'b0;
        bus.wdata  = d;
        bus.wstrb  = strb;
        bus.wlast  = last;
        bus.wvalid = 1'b1;
        for (int k = 0; k < 200 && !ok; k++) begin
            ok = bus.wready;
            tick();
        end
        bus.wvalid = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL w_timeout got=none want=handshake");
        end
    endtask

    task automatic b_recv(output logic [1:0] resp, output logic [3:0] id);
        bit ok = 1'b0;
        resp = 2'bxx;
        id = 4'hx;
        bus.bready = 1'b1;
        for (int k = 0; k < 200 && !ok; k++) begin
            if (bus.bvalid) begin
                ok = 1'b1;
                resp = bus.bresp;
                id = bus.bid;
            end
            tick();
        end
        bus.bready = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL b_timeout got=none want=bvalid");
        end
    endtask

    task automatic ar_send(
        input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
        input logic [2:0] size, input logic [1:0] burst
    );
        bit ok = 1'b0;
        bus.araddr  = a;
        bus.arid    = id;
        bus.arlen   = len;
        bus.arsize  = size;
        bus.arburst = burst;
        bus.arvalid = 1'b1;
        for (int k = 0; k < 200 && !ok; k++) begin
            ok = bus.arready;
            tick();
        end
        bus.arvalid = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL ar_timeout got=none want=handshake");
        end
    endtask

    task automatic r_recv(
        output logic [31:0] d, output logic [1:0] resp,
        output logic last, output logic [3:0] id
    );
        bit ok = 1'b0;
        d = 'x;
        resp = 'x;
        last = 1'bx;
        id = 'x;
        bus.rready = 1'b1;
        for (int k = 0; k < 200 && !ok; k++) begin
            if (bus.rvalid) begin
                ok = 1'b1;
                d = bus.rdata;
                resp = bus.rresp;
                last = bus.rlast;
                id = bus.rid;
            end
            tick();
        end
        bus.rready = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL r_timeout got=none want=rvalid");
        end
    endtask

    task automatic write_burst(
        input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
        input logic [2:0] size, input logic [1:0] burst,
        input logic [3:0] strb, input int last_at,
        output logic [1:0] resp, output logic [3:0] bid
    );
        aw_send(a, id, len, size, burst);
        for (int i = 0; i <= int'(len); i++)
            w_send(wbuf[i], strb, i == last_at);
        b_recv(resp, bid);
    endtask

    task automatic read_burst(
        input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
        input logic [2:0] size, input logic [1:0] burst
    );
        ar_send(a, id, len, size, burst);
        for (int i = 0; i <= int'(len); i++)
            r_recv(rbuf[i], rrsp[i], rlst[i], rids[i]);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        total++;
        if ({bus.awready, bus.wready, bus.bvalid,
             bus.arready, bus.rvalid} !== 5'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=00000",
                {bus.awready, bus.wready, bus.bvalid,
                 bus.arready, bus.rvalid});
        end
        reset = 1'b0;
        tick();
        total++;
        if ({bus.awready, bus.arready} !== 2'b11) begin
            bad++;
            $display("FAIL reset_release got=%b want=11",
                {bus.awready, bus.arready});
        end
    endtask

    task automatic test_single();
        bus.awaddr = 32'h8000_0010;
        bus.awid = 4'd5;
        bus.awlen = 8'd0;
        bus.awsize = 3'd2;
        bus.awburst = 2'b01;
        bus.awvalid = 1'b1;
        total++;
        if (bus.awready !== 1'b1) begin
            bad++;
            $display("FAIL single_awready got=%b want=1", bus.awready);
        end
        tick();
        bus.awvalid = 1'b0;
        total++;
        if (bus.wready !== 1'b1) begin
            bad++;
            $display("FAIL single_wready_cyc1 got=%b want=1", bus.wready);
        end
        bus.wdata = 32'hDEAD_BEEF;
        bus.wstrb = 4'hF;
        bus.wlast = 1'b1;
        bus.wvalid = 1'b1;
        tick();
        bus.wvalid = 1'b0;
        total++;
        if ({bus.bvalid, bus.bresp, bus.bid} !== {1'b1, 2'b00, 4'd5}) begin
            bad++;
            $display("FAIL single_b_cyc2 got=%b/%b/%0d want=1/00/5",
                bus.bvalid, bus.bresp, bus.bid);
        end
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        total++;
        if ({bus.bvalid, bus.awready} !== 2'b01) begin
            bad++;
            $display("FAIL single_after_b got=%b want=01",
                {bus.bvalid, bus.awready});
        end
        bus.araddr = 32'h8000_0010;
        bus.arid = 4'd5;
        bus.arlen = 8'd0;
        bus.arsize = 3'd2;
        bus.arburst = 2'b01;
        bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        total++;
        if ({bus.rvalid, bus.rdata, bus.rresp, bus.rlast, bus.rid} !==
            {1'b1, 32'hDEAD_BEEF, 2'b00, 1'b1, 4'd5}) begin
            bad++;
            $display("FAIL single_r got=%b/%h/%b/%b/%0d want=1/deadbeef/00/1/5",
                bus.rvalid, bus.rdata, bus.rresp, bus.rlast, bus.rid);
        end
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
        total++;
        if ({bus.rvalid, bus.arready} !== 2'b01) begin
            bad++;
            $display("FAIL single_after_r got=%b want=01",
                {bus.rvalid, bus.arready});
        end
    endtask

    task automatic test_incr();
        logic [1:0]  resp;
        logic [3:0]  id;
        logic [31:0] got [4];
        logic        gl [4];
        logic [31:0] held;
        bit          pend = 1'b0;
        int          beats = 0;
        for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
        write_burst(32'h8000_0100, 4'd1, 8'd3, 3'd2, 2'b01, 4'hF, 3,
                    resp, id);
        total++;
        if (resp !== 2'b00 || id !== 4'd1) begin
            bad++;
            $display("FAIL incr_bresp got=%b/%0d want=00/1", resp, id);
        end
        ar_send(32'h8000_0100, 4'd2, 8'd3, 3'd2, 2'b01);
        held = '0;
        for (int k = 0; k < 80 && beats < 4; k++) begin
            bus.rready = (k % 2) == 1;
            if (pend) begin
                total++;
                if (bus.rdata !== held) begin
                    bad++;
                    $display("FAIL incr_stall_stable got=%h want=%h",
                        bus.rdata, held);
                end
                pend = 1'b0;
            end
            if (bus.rvalid) begin
                if (bus.rready) begin
                    got[beats] = bus.rdata;
                    gl[beats] = bus.rlast;
                    beats++;
                end else begin
                    held = bus.rdata;
                    pend = 1'b1;
                end
            end
            tick();
        end
        bus.rready = 1'b0;
        total++;
        if (beats != 4) begin
            bad++;
            $display("FAIL incr_beats got=%0d want=4", beats);
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (got[i] !== 32'(i + 1) || gl[i] !== (i == 3)) begin
                    bad++;
                    $display("FAIL incr_beat%0d got=%h/%b want=%h/%b",
                        i, got[i], gl[i], i + 1, i == 3);
                end
            end
        end
    endtask

    task automatic test_strobe();
        logic [1:0] resp;
        logic [3:0] id;
        wbuf[0] = 32'h1122_3344;
        write_burst(32'h8000_0200, 4'd2, 8'd0, 3'd2, 2'b01, 4'hF, 0,
                    resp, id);
        wbuf[0] = 32'hAABB_CCDD;
        write_burst(32'h8000_0200, 4'd2, 8'd0, 3'd2, 2'b01, 4'b0010, 0,
                    resp, id);
        read_burst(32'h8000_0200, 4'd2, 8'd0, 3'd2, 2'b01);
        total++;
        if (rbuf[0] !== 32'h1122_CC44) begin
            bad++;
            $display("FAIL strobe_merge got=%h want=1122cc44", rbuf[0]);
        end
    endtask

    task automatic test_decerr();
        logic [1:0] resp;
        logic [3:0] id;
        wbuf[0] = 32'hCAFE_F00D;
        write_burst(32'h8000_0000, 4'd3, 8'd0, 3'd2, 2'b01, 4'hF, 0,
                    resp, id);
        read_burst(32'h8000_1000, 4'd4, 8'd0, 3'd2, 2'b01);
        total++;
        if (rrsp[0] !== 2'b11 || rbuf[0] !== 32'd0) begin
            bad++;
            $display("FAIL decerr_read got=%b/%h want=11/0", rrsp[0], rbuf[0]);
        end
        wbuf[0] = 32'h1234_5678;
        write_burst(32'h8000_1000, 4'd6, 8'd0, 3'd2, 2'b01, 4'hF, 0,
                    resp, id);
        total++;
        if (resp !== 2'b11 || id !== 4'd6) begin
            bad++;
            $display("FAIL decerr_write got=%b/%0d want=11/6", resp, id);
        end
        read_burst(32'h8000_0000, 4'd4, 8'd0, 3'd2, 2'b01);
        total++;
        if (rbuf[0] !== 32'hCAFE_F00D) begin
            bad++;
            $display("FAIL decerr_word0 got=%h want=cafef00d", rbuf[0]);
        end
        read_burst(32'h8000_0FFC, 4'd4, 8'd1, 3'd2, 2'b01);
        total++;
        if (rrsp[0] !== 2'b00 || rrsp[1] !== 2'b11 || rbuf[1] !== 32'd0 ||
            rlst[1] !== 1'b1) begin
            bad++;
            $display("FAIL decerr_edge got=%b/%b/%h want=00/11/0",
                rrsp[0], rrsp[1], rbuf[1]);
        end
        read_burst(32'h7FFF_FFFC, 4'd4, 8'd0, 3'd2, 2'b01);
        total++;
        if (rrsp[0] !== 2'b11) begin
            bad++;
            $display("FAIL decerr_below got=%b want=11", rrsp[0]);
        end
    endtask

    task automatic test_fixed_slverr();
        logic [1:0] resp;
        logic [3:0] id;
        wbuf[0] = 32'd5;
        wbuf[1] = 32'd6;
        wbuf[2] = 32'd7;
        write_burst(32'h8000_0020, 4'd7, 8'd2, 3'd2, 2'b00, 4'hF, 2,
                    resp, id);
        read_burst(32'h8000_0020, 4'd7, 8'd0, 3'd2, 2'b01);
        total++;
        if (resp !== 2'b00 || rbuf[0] !== 32'd7) begin
            bad++;
            $display("FAIL fixed_write got=%b/%h want=00/7", resp, rbuf[0]);
        end
        wbuf[0] = 32'h99;
        write_burst(32'h8000_0020, 4'd7, 8'd0, 3'd2, 2'b10, 4'hF, 0,
                    resp, id);
        read_burst(32'h8000_0020, 4'd7, 8'd0, 3'd2, 2'b01);
        total++;
        if (resp !== 2'b10 || rbuf[0] !== 32'd7) begin
            bad++;
            $display("FAIL slverr_burst got=%b/%h want=10/7", resp, rbuf[0]);
        end
        wbuf[0] = 32'hA;
        wbuf[1] = 32'hB;
        write_burst(32'h8000_0030, 4'd8, 8'd1, 3'd2, 2'b01, 4'hF, 0,
                    resp, id);
        total++;
        if (resp !== 2'b10) begin
            bad++;
            $display("FAIL slverr_wlast got=%b want=10", resp);
        end
        read_burst(32'h8000_0030, 4'd8, 8'd1, 3'd2, 2'b01);
        total++;
        if (rbuf[0] !== 32'hA || rbuf[1] !== 32'hB ||
            rrsp[0] !== 2'b00 || rrsp[1] !== 2'b00) begin
            bad++;
            $display("FAIL slverr_wlast_data got=%h/%h want=a/b",
                rbuf[0], rbuf[1]);
        end
        read_burst(32'h8000_0020, 4'd9, 8'd1, 3'd2, 2'b10);
        total++;
        if (rrsp[0] !== 2'b10 || rrsp[1] !== 2'b10 || rbuf[0] !== 32'd0 ||
            rbuf[1] !== 32'd0 || rlst[0] !== 1'b0 || rlst[1] !== 1'b1) begin
            bad++;
            $display("FAIL slverr_read got=%b/%b/%h/%b%b want=10/10/0/01",
                rrsp[0], rrsp[1], rbuf[0], rlst[0], rlst[1]);
        end
    endtask

    task automatic test_concurrent();
        logic [1:0] resp;
        logic [3:0] id;
        for (int i = 0; i < 8; i++) wbuf[i] = 32'h3000_0000 + 32'(i);
        write_burst(32'h8000_0300, 4'd1, 8'd7, 3'd2, 2'b01, 4'hF, 7,
                    resp, id);
        for (int i = 0; i < 8; i++) wbuf[i] = 32'h4000_0000 + 32'(i);
        fork
            begin
                logic [1:0] br;
                logic [3:0] bi;
                int         err = 0;
                aw_send(32'h8000_0400, 4'd9, 8'd7, 3'd2, 2'b01);
                for (int i = 0; i < 8; i++) w_send(wbuf[i], 4'hF, i == 7);
                for (int k = 0; k < 20 && !bus.bvalid; k++) tick();
                for (int k = 0; k < 10; k++) begin
                    if ({bus.bvalid, bus.bid, bus.awready} !==
                        {1'b1, 4'd9, 1'b0}) err++;
                    tick();
                end
                total++;
                if (err != 0) begin
                    bad++;
                    $display("FAIL conc_b_hold got=%0d bad cycles want=0", err);
                end
                b_recv(br, bi);
                total++;
                if (br !== 2'b00 || bi !== 4'd9) begin
                    bad++;
                    $display("FAIL conc_bresp got=%b/%0d want=00/9", br, bi);
                end
            end
            begin
                read_burst(32'h8000_0300, 4'd3, 8'd7, 3'd2, 2'b01);
                for (int i = 0; i < 8; i++) begin
                    total++;
                    if (rbuf[i] !== 32'h3000_0000 + 32'(i) ||
                        rids[i] !== 4'd3 || rlst[i] !== (i == 7)) begin
                        bad++;
                        $display("FAIL conc_r%0d got=%h/%0d want=%h/3",
                            i, rbuf[i], rids[i], 32'h3000_0000 + 32'(i));
                    end
                end
            end
        join
        read_burst(32'h8000_041C, 4'd3, 8'd0, 3'd2, 2'b01);
        total++;
        if (rbuf[0] !== 32'h4000_0007) begin
            bad++;
            $display("FAIL conc_wdata got=%h want=40000007", rbuf[0]);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic [1:0]  r;
        logic        l;
        logic [3:0]  i;
        ar_send(32'h8000_0300, 4'd3, 8'd7, 3'd2, 2'b01);
        for (int k = 0; k < 3; k++) r_recv(d, r, l, i);
        bus.rready = 1'b1;
        reset = 1'b1;
        tick();
        total++;
        if ({bus.rvalid, bus.arready, bus.awready} !== 3'b000) begin
            bad++;
            $display("FAIL reset_mid got=%b want=000",
                {bus.rvalid, bus.arready, bus.awready});
        end
        reset = 1'b0;
        bus.rready = 1'b0;
        tick();
        total++;
        if ({bus.rvalid, bus.arready} !== 2'b01) begin
            bad++;
            $display("FAIL reset_mid_release got=%b want=01",
                {bus.rvalid, bus.arready});
        end
        read_burst(32'h8000_0304, 4'd3, 8'd0, 3'd2, 2'b01);
        total++;
        if (rbuf[0] !== 32'h3000_0001) begin
            bad++;
            $display("FAIL reset_mem_kept got=%h want=30000001", rbuf[0]);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b1;
        bus.awvalid = 1'b0;
        bus.awaddr = '0;
        bus.awid = '0;
        bus.awlen = '0;
        bus.awsize = '0;
        bus.awburst = '0;
        bus.wvalid = 1'b0;
        bus.wdata = '0;
        bus.wstrb = '0;
        bus.wlast = 1'b0;
        bus.bready = 1'b0;
        bus.arvalid = 1'b0;
        bus.araddr = '0;
        bus.arid = '0;
        bus.arlen = '0;
        bus.arsize = '0;
        bus.arburst = '0;
        bus.rready = 1'b0;
        test_reset();
        test_single();
        test_incr();
        test_strobe();
        test_decerr();
        test_fixed_slverr();
        test_concurrent();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
